// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises a PLL from its own free-running reference clock. Pulses the PLL
// reset, waits for the PLL lock indication, qualifies it over a run of
// consecutive locked cycles, then releases NUM_CH downstream reset domains one
// after another. Lock lost after qualification restarts the whole sequence and
// is counted. Too many consecutive lock timeouts park the block in a terminal
// failure state that only RSTN leaves.
//
// Parameters
//   NUM_CH        number of downstream reset domains (1..8)
//   RST_CYCLES    PLL_RST pulse width in CLKI cycles (>=1)
//   LOCK_TIMEOUT  cycles allowed for lock before a retry (>=1)
//   STABLE_CYCLES consecutive locked cycles required before release (>=1)
//   STAGGER       cycles between successive domain releases (>=1)
//   RETRY_MAX     consecutive timeouts before FAIL, 0 = retry forever
//   CNT_W         width of LOSS_CNT
//
// Ports
//   CLKI       in   reference clock (also the PLL input clock)
//   RSTN       in   asynchronous active-low reset
//   PLL_LOCK   in   PLL lock output, asynchronous to CLKI
//   CLR_LOSS   in   synchronous clear of LOSS_CNT
//   PLL_RST    out  active-high PLL reset
//   RST_OUT_N  out  active-low per-domain resets, bit 0 released first
//   LOCKED     out  all domains released with lock qualified
//   FAIL       out  retry budget exhausted
//   LOSS_CNT   out  saturating count of lock-loss events after qualification
//
// Every output is a flop; no input reaches an output combinationally.

module pll_lock_supervisor #(
    parameter int NUM_CH        = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int STAGGER       = 8,
    parameter int RETRY_MAX     = 3,
    parameter int CNT_W         = 8
) (
    input  logic              CLKI,
    input  logic              RSTN,
    input  logic              PLL_LOCK,
    input  logic              CLR_LOSS,
    output logic              PLL_RST,
    output logic [NUM_CH-1:0] RST_OUT_N,
    output logic              LOCKED,
    output logic              FAIL,
    output logic [CNT_W-1:0]  LOSS_CNT
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // S_RELEASE spends this many cycles before handing over to S_RUN.
    localparam int REL_CYCLES = STAGGER * (NUM_CH - 1) + 1;

    // One shared phase timer covers every state; size it for the longest.
    localparam int TMR_MAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                  max2(STABLE_CYCLES, REL_CYCLES));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   WAIT_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   REL_END     = TMR_W'(REL_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_inc;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_inc;
    logic               lock_p0;
    logic               lock_s;
    logic               loss_evt;

    // Thermometer of released domains: bit k is free once `elapsed` cycles
    // since entering S_RELEASE reach STAGGER*k.
    function automatic logic [NUM_CH-1:0] rel_mask(input logic [TMR_W-1:0] elapsed);
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m[k] = (int'(elapsed) >= STAGGER * k);
        end
        return m;
    endfunction

    // Saturating loss counter; a clear coinciding with a loss leaves one
    // count so that event is not lost.
    function automatic logic [CNT_W-1:0] loss_next(input logic [CNT_W-1:0] cur,
                                                   input logic             clr,
                                                   input logic             loss);
        if (clr) begin
            return loss ? CNT_W'(1) : '0;
        end
        if (loss && (cur != {CNT_W{1'b1}})) begin
            return cur + CNT_W'(1);
        end
        return cur;
    endfunction

    // ---- stage p0/s: two-flop synchroniser for the asynchronous lock ----
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= PLL_LOCK;
            lock_s  <= lock_p0;
        end
    end

    always_comb begin
        tmr_inc   = tmr + TMR_W'(1);
        retry_inc = retry + RETRY_W'(1);
        loss_evt  = !lock_s && ((state == S_RELEASE) || (state == S_RUN));
    end

    // ---- stage fsm: sequencing state machine with registered outputs ----
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_RST;
            tmr       <= '0;
            retry     <= '0;
            PLL_RST   <= 1'b1;
            RST_OUT_N <= '0;
            LOCKED    <= 1'b0;
            FAIL      <= 1'b0;
            LOSS_CNT  <= '0;
        end else begin
            LOSS_CNT <= loss_next(LOSS_CNT, CLR_LOSS, loss_evt);

            case (state)
                S_RST: begin
                    if (tmr == RST_LAST) begin
                        state   <= S_WAIT;
                        tmr     <= '0;
                        PLL_RST <= 1'b0;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end

                S_WAIT: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        tmr   <= '0;
                    end else if (tmr == WAIT_LAST) begin
                        tmr     <= '0;
                        PLL_RST <= 1'b1;
                        // With RETRY_MAX = 0 the count is never consulted,
                        // so it is frozen rather than left to wrap.
                        if (RETRY_MAX != 0) begin
                            retry <= retry_inc;
                        end
                        if ((RETRY_MAX != 0) && (retry_inc == RETRY_LIM)) begin
                            state <= S_FAIL;
                            FAIL  <= 1'b1;
                        end else begin
                            state <= S_RST;
                        end
                    end else begin
                        tmr <= tmr_inc;
                    end
                end

                S_STABLE: begin
                    if (!lock_s) begin
                        // A glitch is not a timeout: restart the lock wait
                        // without spending a retry.
                        state <= S_WAIT;
                        tmr   <= '0;
                    end else if (tmr == STABLE_LAST) begin
                        state     <= S_RELEASE;
                        tmr       <= '0;
                        retry     <= '0;
                        RST_OUT_N <= rel_mask('0);
                    end else begin
                        tmr <= tmr_inc;
                    end
                end

                S_RELEASE: begin
                    if (!lock_s) begin
                        state     <= S_RST;
                        tmr       <= '0;
                        PLL_RST   <= 1'b1;
                        RST_OUT_N <= '0;
                        LOCKED    <= 1'b0;
                    end else begin
                        tmr       <= tmr_inc;
                        RST_OUT_N <= rel_mask(tmr_inc);
                        if (tmr_inc == REL_END) begin
                            state  <= S_RUN;
                            LOCKED <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_RST;
                        tmr       <= '0;
                        PLL_RST   <= 1'b1;
                        RST_OUT_N <= '0;
                        LOCKED    <= 1'b0;
                    end
                end

                S_FAIL: begin
                    PLL_RST   <= 1'b1;
                    RST_OUT_N <= '0;
                    LOCKED    <= 1'b0;
                    FAIL      <= 1'b1;
                end

                default: begin
                    state     <= S_RST;
                    tmr       <= '0;
                    PLL_RST   <= 1'b1;
                    RST_OUT_N <= '0;
                    LOCKED    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with NUM_CH=3, RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGGER=3, RETRY_MAX=2, CNT_W=4.
// The stimulus process queues hand-computed output vectors tagged with the
// clock cycle at which they must hold; a monitor pops and compares them on
// the falling edge (or immediately, for asynchronous-reset probes).

module tb_pll_lock_supervisor;

    logic       CLKI;
    logic       RSTN;
    logic       PLL_LOCK;
    logic       CLR_LOSS;
    logic       PLL_RST;
    logic [2:0] RST_OUT_N;
    logic       LOCKED;
    logic       FAIL;
    logic [3:0] LOSS_CNT;

    pll_lock_supervisor #(
        .NUM_CH       (3),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .STAGGER      (3),
        .RETRY_MAX    (2),
        .CNT_W        (4)
    ) dut (
        .CLKI     (CLKI),
        .RSTN     (RSTN),
        .PLL_LOCK (PLL_LOCK),
        .CLR_LOSS (CLR_LOSS),
        .PLL_RST  (PLL_RST),
        .RST_OUT_N(RST_OUT_N),
        .LOCKED   (LOCKED),
        .FAIL     (FAIL),
        .LOSS_CNT (LOSS_CNT)
    );

    initial CLKI = 1'b0;
    always #5 CLKI = ~CLKI;

    int cyc = 0;
    always @(posedge CLKI) cyc <= cyc + 1;

    // Packed output vector {PLL_RST, RST_OUT_N, LOCKED, FAIL, LOSS_CNT}
    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    logic probe_pending = 1'b0;
    event probe_ev;

    function automatic logic [9:0] mk(input logic pr, input logic [2:0] ro,
                                      input logic lk, input logic fl,
                                      input logic [3:0] lc);
        return {pr, ro, lk, fl, lc};
    endfunction

    localparam logic [9:0] RST_V = 10'b1_000_0_0_0000;

    task automatic expect_span(input int c0, input int c1, input string nm,
                               input logic [9:0] v);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.cyc  = c;
            e.name = nm;
            e.exp  = v;
            sb.push_back(e);
        end
    endtask

    task automatic probe(input string nm, input logic [9:0] v);
        exp_t e;
        e.cyc  = -1;
        e.name = nm;
        e.exp  = v;
        sb.push_back(e);
        probe_pending = 1'b1;
        -> probe_ev;
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge CLKI);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge CLKI);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Asserts RSTN between clock edges and checks the outputs before any
    // edge arrives; returns the cycle at which RSTN was released.
    task automatic apply_reset(input logic lock_val, output int base);
        drain();
        @(negedge CLKI);
        #1;
        RSTN     = 1'b0;
        PLL_LOCK = lock_val;
        CLR_LOSS = 1'b0;
        #1;
        probe("async_reset", RST_V);
        base = cyc;
        expect_span(base + 1, base + 2, "reset_hold", RST_V);
        goto_cyc(base + 2);
        RSTN = 1'b1;
        base = cyc;
    endtask

    // Entered with LOCKED=1 at a falling edge: drops PLL_LOCK, checks the
    // registered drop, then relocks and checks the full re-release.
    task automatic loss_iter(input logic [3:0] lc_old, input logic [3:0] lc_new,
                             input bit clr, input bit abort);
        int c;
        c = cyc;
        PLL_LOCK = 1'b0;
        expect_span(c + 1, c + 2, "pre_loss", mk(1'b0, 3'b111, 1'b1, 1'b0, lc_old));
        expect_span(c + 3, c + 6, "loss_drop", mk(1'b1, 3'b000, 1'b0, 1'b0, lc_new));
        expect_span(c + 7, c + 15, "loss_wait", mk(1'b0, 3'b000, 1'b0, 1'b0, lc_new));
        expect_span(c + 16, c + 16, "loss_rel0", mk(1'b0, 3'b001, 1'b0, 1'b0, lc_new));
        if (clr) begin
            goto_cyc(c + 2);
            CLR_LOSS = 1'b1;
        end
        goto_cyc(c + 3);
        CLR_LOSS = 1'b0;
        PLL_LOCK = 1'b1;
        if (!abort) begin
            expect_span(c + 17, c + 18, "loss_rel0", mk(1'b0, 3'b001, 1'b0, 1'b0, lc_new));
            expect_span(c + 19, c + 21, "loss_rel1", mk(1'b0, 3'b011, 1'b0, 1'b0, lc_new));
            expect_span(c + 22, c + 22, "loss_rel2", mk(1'b0, 3'b111, 1'b0, 1'b0, lc_new));
            expect_span(c + 23, c + 29, "loss_relock", mk(1'b0, 3'b111, 1'b1, 1'b0, lc_new));
            goto_cyc(c + 30);
        end
    endtask

    // Monitor: compares queued expectations as their cycle comes due.
    initial begin : monitor
        exp_t       e;
        logic [9:0] got;
        forever begin
            @(negedge CLKI or probe_ev);
            if (probe_pending) begin
                probe_pending = 1'b0;
                if (sb.size() > 0 && sb[0].cyc < 0) begin
                    e   = sb.pop_front();
                    got = {PLL_RST, RST_OUT_N, LOCKED, FAIL, LOSS_CNT};
                    nvec++;
                    if (got !== e.exp) begin
                        nerr++;
                        $display("FAIL %s t=%0t got pll_rst=%b rst_out_n=%b locked=%b fail=%b loss_cnt=%0d required pll_rst=%b rst_out_n=%b locked=%b fail=%b loss_cnt=%0d",
                                 e.name, $time, got[9], got[8:6], got[5], got[4], got[3:0],
                                 e.exp[9], e.exp[8:6], e.exp[5], e.exp[4], e.exp[3:0]);
                    end
                end
            end else begin
                while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
                    e   = sb.pop_front();
                    got = {PLL_RST, RST_OUT_N, LOCKED, FAIL, LOSS_CNT};
                    nvec++;
                    if (e.cyc < cyc) begin
                        nerr++;
                        $display("FAIL %s cycle %0d not sampled (now %0d), required on time", e.name, e.cyc, cyc);
                    end else if (got !== e.exp) begin
                        nerr++;
                        $display("FAIL %s cyc=%0d got pll_rst=%b rst_out_n=%b locked=%b fail=%b loss_cnt=%0d required pll_rst=%b rst_out_n=%b locked=%b fail=%b loss_cnt=%0d",
                                 e.name, cyc, got[9], got[8:6], got[5], got[4], got[3:0],
                                 e.exp[9], e.exp[8:6], e.exp[5], e.exp[4], e.exp[3:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int b;
        RSTN     = 1'b0;
        PLL_LOCK = 1'b0;
        CLR_LOSS = 1'b0;

        // Clean bring-up: lock appears at cycle 10 after release
        apply_reset(1'b0, b);
        expect_span(b + 1,  b + 3,  "a_pll_rst", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 4,  b + 19, "a_wait",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 20, b + 22, "a_rel0",    mk(1'b0, 3'b001, 1'b0, 1'b0, 4'd0));
        expect_span(b + 23, b + 25, "a_rel1",    mk(1'b0, 3'b011, 1'b0, 1'b0, 4'd0));
        expect_span(b + 26, b + 26, "a_rel2",    mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
        expect_span(b + 27, b + 35, "a_locked",  mk(1'b0, 3'b111, 1'b1, 1'b0, 4'd0));
        goto_cyc(b + 9);
        PLL_LOCK = 1'b1;
        goto_cyc(b + 35);

        // Lock loss in RUN, 16 times: counter saturates at 15
        for (int i = 1; i <= 16; i++) begin
            loss_iter(4'((i - 1 > 15) ? 15 : i - 1), 4'((i > 15) ? 15 : i), 1'b0, 1'b0);
        end

        // Clear alone, rebuild to 5, then clear coinciding with a loss
        CLR_LOSS = 1'b1;
        expect_span(cyc + 1, cyc + 1, "clr_only", mk(1'b0, 3'b111, 1'b1, 1'b0, 4'd0));
        goto_cyc(cyc + 1);
        CLR_LOSS = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            loss_iter(4'(i - 1), 4'(i), 1'b0, 1'b0);
        end
        loss_iter(4'd5, 4'd1, 1'b1, 1'b1);

        // Async reset lands mid-release; then glitchy lock with PLL_LOCK high
        apply_reset(1'b1, b);
        expect_span(b + 1,  b + 3,  "g_pll_rst", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 4,  b + 19, "g_hold",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 20, b + 22, "g_rel0",    mk(1'b0, 3'b001, 1'b0, 1'b0, 4'd0));
        expect_span(b + 23, b + 25, "g_rel1",    mk(1'b0, 3'b011, 1'b0, 1'b0, 4'd0));
        expect_span(b + 26, b + 26, "g_rel2",    mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
        expect_span(b + 27, b + 30, "g_locked",  mk(1'b0, 3'b111, 1'b1, 1'b0, 4'd0));
        goto_cyc(b + 8);
        PLL_LOCK = 1'b0;
        goto_cyc(b + 9);
        PLL_LOCK = 1'b1;
        goto_cyc(b + 30);

        // Timeout then success
        apply_reset(1'b0, b);
        expect_span(b + 1,  b + 3,  "t_pll_rst1", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 4,  b + 35, "t_wait1",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 36, b + 39, "t_pll_rst2", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 40, b + 48, "t_wait2",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 49, b + 51, "t_rel0",     mk(1'b0, 3'b001, 1'b0, 1'b0, 4'd0));
        expect_span(b + 52, b + 54, "t_rel1",     mk(1'b0, 3'b011, 1'b0, 1'b0, 4'd0));
        expect_span(b + 55, b + 55, "t_rel2",     mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
        expect_span(b + 56, b + 60, "t_locked",   mk(1'b0, 3'b111, 1'b1, 1'b0, 4'd0));
        goto_cyc(b + 36);
        PLL_LOCK = 1'b1;
        goto_cyc(b + 60);

        // Hard failure: two pulses, then FAIL held even once lock appears
        apply_reset(1'b0, b);
        expect_span(b + 1,  b + 3,   "f_pll_rst1", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 4,  b + 35,  "f_wait1",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 36, b + 39,  "f_pll_rst2", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 40, b + 71,  "f_wait2",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 72, b + 100, "f_fail",     mk(1'b1, 3'b000, 1'b0, 1'b1, 4'd0));
        goto_cyc(b + 80);
        PLL_LOCK = 1'b1;
        goto_cyc(b + 100);

        // Only RSTN leaves the failure state
        apply_reset(1'b0, b);
        expect_span(b + 1, b + 3, "r_pll_rst", mk(1'b1, 3'b000, 1'b0, 1'b0, 4'd0));
        expect_span(b + 4, b + 6, "r_wait",    mk(1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        goto_cyc(b + 6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
